// File: rtl/time_keeper.sv
// Time-of-day core: divides CLK to one-second ticks, keeps 12-hour BCD time with AM/PM, supports key-driven setting.
// Latency: all outputs registered; a terminal prescaler count or key edge in cycle N is visible in cycle N+1.
// Backpressure: none; keys are level inputs sampled every cycle, outputs are free-running.
module time_keeper #(
    parameter int TICKS_PER_SEC = 1000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       TIMESET_RUN,
    input  logic       SW_F1,
    input  logic       SW_F2,
    output logic       AMPM,
    output logic [3:0] HOUR,
    output logic [2:0] MINHIGH,
    output logic [3:0] MINLOW,
    output logic [2:0] SECHIGH,
    output logic [3:0] SECLOW,
    output logic       SEC_TICK,
    output logic       MIN_TICK
);

    localparam int            PW         = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic          ampm_q, ampm_d;
    logic [3:0]    hour_q, hour_d;
    logic [2:0]    min_hi_q, min_hi_d;
    logic [3:0]    min_lo_q, min_lo_d;
    logic [2:0]    sec_hi_q, sec_hi_d;
    logic [3:0]    sec_lo_q, sec_lo_d;
    logic          sec_tick_q, sec_tick_d;
    logic          min_tick_q, min_tick_d;
    logic          f1_hist_q, f1_hist_d;
    logic          f2_hist_q, f2_hist_d;

    logic          f1_rise;
    logic          f2_rise;
    logic          sec_at_59;
    logic          min_at_59;
    logic          adv_min;
    logic          adv_hour;

    assign f1_rise   = SW_F1 & ~f1_hist_q;
    assign f2_rise   = SW_F2 & ~f2_hist_q;
    assign sec_at_59 = (sec_hi_q == 3'd5) && (sec_lo_q == 4'd9);
    assign min_at_59 = (min_hi_q == 3'd5) && (min_lo_q == 4'd9);

    // Next-state: prescaler, seconds chain in run mode, key adjustments in set mode.
    always_comb begin
        presc_d    = presc_q;
        ampm_d     = ampm_q;
        hour_d     = hour_q;
        min_hi_d   = min_hi_q;
        min_lo_d   = min_lo_q;
        sec_hi_d   = sec_hi_q;
        sec_lo_d   = sec_lo_q;
        sec_tick_d = 1'b0;
        min_tick_d = 1'b0;
        f1_hist_d  = SW_F1;
        f2_hist_d  = SW_F2;
        adv_min    = 1'b0;
        adv_hour   = 1'b0;

        if (TIMESET_RUN) begin
            // Set mode: seconds and prescaler parked at zero, keys step minute and hour independently.
            presc_d  = '0;
            sec_hi_d = 3'd0;
            sec_lo_d = 4'd0;
            adv_min  = f2_rise;
            adv_hour = f1_rise;
        end else if (presc_q == PRESC_LAST) begin
            presc_d    = '0;
            sec_tick_d = 1'b1;
            min_tick_d = sec_at_59;
            if (sec_lo_q == 4'd9) begin
                sec_lo_d = 4'd0;
                if (sec_hi_q == 3'd5) begin
                    sec_hi_d = 3'd0;
                end else begin
                    sec_hi_d = sec_hi_q + 3'd1;
                end
            end else begin
                sec_lo_d = sec_lo_q + 4'd1;
            end
            adv_min  = sec_at_59;
            adv_hour = sec_at_59 && min_at_59;
        end else begin
            presc_d = presc_q + PW'(1);
        end

        if (adv_min) begin
            if (min_lo_q == 4'd9) begin
                min_lo_d = 4'd0;
                if (min_hi_q == 3'd5) begin
                    min_hi_d = 3'd0;
                end else begin
                    min_hi_d = min_hi_q + 3'd1;
                end
            end else begin
                min_lo_d = min_lo_q + 4'd1;
            end
        end

        if (adv_hour) begin
            if (hour_q == 4'd11) begin
                hour_d = 4'd0;
                ampm_d = ~ampm_q;
            end else begin
                hour_d = hour_q + 4'd1;
            end
        end
    end

    // State registers; reset overrides mode, keys and prescaler.
    always_ff @(posedge CLK) begin
        if (RST) begin
            presc_q    <= '0;
            ampm_q     <= 1'b0;
            hour_q     <= 4'd0;
            min_hi_q   <= 3'd0;
            min_lo_q   <= 4'd0;
            sec_hi_q   <= 3'd0;
            sec_lo_q   <= 4'd0;
            sec_tick_q <= 1'b0;
            min_tick_q <= 1'b0;
            f1_hist_q  <= 1'b0;
            f2_hist_q  <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            ampm_q     <= ampm_d;
            hour_q     <= hour_d;
            min_hi_q   <= min_hi_d;
            min_lo_q   <= min_lo_d;
            sec_hi_q   <= sec_hi_d;
            sec_lo_q   <= sec_lo_d;
            sec_tick_q <= sec_tick_d;
            min_tick_q <= min_tick_d;
            f1_hist_q  <= f1_hist_d;
            f2_hist_q  <= f2_hist_d;
        end
    end

    assign AMPM     = ampm_q;
    assign HOUR     = hour_q;
    assign MINHIGH  = min_hi_q;
    assign MINLOW   = min_lo_q;
    assign SECHIGH  = sec_hi_q;
    assign SECLOW   = sec_lo_q;
    assign SEC_TICK = sec_tick_q;
    assign MIN_TICK = min_tick_q;

endmodule

// File: tb/tb_time_keeper.sv
// Bench for time_keeper: directed time-setting scenarios plus randomized mode/key traffic.
// Expected outputs come from a seconds-of-day model and are queued per cycle for a separate monitor.
// Directed end-points are additionally compared against hand-derived constants.
module tb_time_keeper;

    localparam int TPS = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tsr = 1'b0;
    logic       f1  = 1'b0;
    logic       f2  = 1'b0;
    logic       AMPM;
    logic [3:0] HOUR;
    logic [2:0] MINHIGH;
    logic [3:0] MINLOW;
    logic [2:0] SECHIGH;
    logic [3:0] SECLOW;
    logic       SEC_TICK;
    logic       MIN_TICK;

    typedef struct packed {
        logic       ampm;
        logic [3:0] hour;
        logic [2:0] mh;
        logic [3:0] ml;
        logic [2:0] sh;
        logic [3:0] sl;
        logic       st;
        logic       mt;
    } obs_t;

    obs_t act;
    obs_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: time of day as seconds since midnight, 0..86399.
    int m_tod   = 0;
    int m_presc = 0;
    bit m_f1h   = 1'b0;
    bit m_f2h   = 1'b0;
    bit m_st    = 1'b0;
    bit m_mt    = 1'b0;

    time_keeper #(.TICKS_PER_SEC(TPS)) dut (
        .CLK        (clk),
        .RST        (rst),
        .TIMESET_RUN(tsr),
        .SW_F1      (f1),
        .SW_F2      (f2),
        .AMPM       (AMPM),
        .HOUR       (HOUR),
        .MINHIGH    (MINHIGH),
        .MINLOW     (MINLOW),
        .SECHIGH    (SECHIGH),
        .SECLOW     (SECLOW),
        .SEC_TICK   (SEC_TICK),
        .MIN_TICK   (MIN_TICK)
    );

    assign act = {AMPM, HOUR, MINHIGH, MINLOW, SECHIGH, SECLOW, SEC_TICK, MIN_TICK};

    always #5 clk = ~clk;

    function automatic obs_t mk(int ap, int hr, int mh, int ml, int sh, int sl, int st, int mt);
        obs_t o;
        o.ampm = ap[0];
        o.hour = hr[3:0];
        o.mh   = mh[2:0];
        o.ml   = ml[3:0];
        o.sh   = sh[2:0];
        o.sl   = sl[3:0];
        o.st   = st[0];
        o.mt   = mt[0];
        return o;
    endfunction

    function automatic obs_t model_obs();
        int h24;
        int mins;
        int secs;
        h24  = m_tod / 3600;
        mins = (m_tod / 60) % 60;
        secs = m_tod % 60;
        return mk((h24 >= 12) ? 1 : 0, h24 % 12, mins / 10, mins % 10,
                  secs / 10, secs % 10, int'(m_st), int'(m_mt));
    endfunction

    // Drive one cycle of inputs, advance the model by that cycle and queue the expected outputs.
    task automatic run_cycle(bit r, bit s, bit k1, bit k2);
        int mm;
        @(negedge clk);
        rst = r;
        tsr = s;
        f1  = k1;
        f2  = k2;
        m_st = 1'b0;
        m_mt = 1'b0;
        if (r) begin
            m_tod   = 0;
            m_presc = 0;
            k1      = 1'b0;
            k2      = 1'b0;
        end else if (s) begin
            m_presc = 0;
            m_tod   = m_tod - (m_tod % 60);
            if (k1 && !m_f1h) m_tod = (m_tod + 3600) % 86400;
            if (k2 && !m_f2h) begin
                mm    = (m_tod / 60) % 60;
                m_tod = m_tod - mm * 60 + ((mm + 1) % 60) * 60;
            end
        end else if (m_presc == TPS - 1) begin
            m_presc = 0;
            m_st    = 1'b1;
            m_mt    = (m_tod % 60 == 59);
            m_tod   = (m_tod + 1) % 86400;
        end else begin
            m_presc = m_presc + 1;
        end
        m_f1h = k1;
        m_f2h = k2;
        exp_q.push_back(model_obs());
    endtask

    task automatic pulse_f1(int n);
        repeat (n) begin
            run_cycle(1'b0, 1'b1, 1'b1, 1'b0);
            run_cycle(1'b0, 1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic pulse_f2(int n);
        repeat (n) begin
            run_cycle(1'b0, 1'b1, 1'b0, 1'b1);
            run_cycle(1'b0, 1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic run_n(int n, bit wiggle);
        repeat (n) begin
            if (wiggle) run_cycle(1'b0, 1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)));
            else        run_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    // Compare the outputs produced by the most recently driven cycle against a constant.
    task automatic expect_now(string name, obs_t want);
        @(posedge clk);
        #1;
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %b %0d %0d%0d:%0d%0d st=%b mt=%b, expected %b %0d %0d%0d:%0d%0d st=%b mt=%b",
                     name, act.ampm, act.hour, act.mh, act.ml, act.sh, act.sl, act.st, act.mt,
                     want.ampm, want.hour, want.mh, want.ml, want.sh, want.sl, want.st, want.mt);
        end
    endtask

    // Monitor: outputs are presented every cycle; pop and compare one expectation per cycle.
    initial begin
        obs_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL scoreboard t=%0t: got %h expected %h", $time, act, e);
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  cyc;
        int  seg;
        bit  s;
        bit  r;

        run_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        run_cycle(1'b1, 1'b0, 1'b1, 1'b1);
        expect_now("reset_state", mk(0, 0, 0, 0, 0, 0, 0, 0));

        run_n(240, 1'b1);
        expect_now("one_minute", mk(0, 0, 0, 1, 0, 0, 1, 1));

        run_cycle(1'b0, 1'b1, 1'b0, 1'b0);
        pulse_f1(11);
        expect_now("hour11_am", mk(0, 11, 0, 1, 0, 0, 0, 0));
        pulse_f1(1);
        expect_now("hour12_pm", mk(1, 0, 0, 1, 0, 0, 0, 0));
        repeat (20) run_cycle(1'b0, 1'b1, 1'b1, 1'b0);
        run_cycle(1'b0, 1'b1, 1'b0, 1'b0);
        expect_now("held_key_once", mk(1, 1, 0, 1, 0, 0, 0, 0));

        pulse_f1(10);
        pulse_f2(58);
        expect_now("set_1159pm", mk(1, 11, 5, 9, 0, 0, 0, 0));
        run_n(240, 1'b0);
        expect_now("midnight_rollover", mk(0, 0, 0, 0, 0, 0, 1, 1));

        run_cycle(1'b0, 1'b1, 1'b0, 1'b0);
        pulse_f1(3);
        pulse_f2(59);
        expect_now("h3_m59", mk(0, 3, 5, 9, 0, 0, 0, 0));
        run_cycle(1'b0, 1'b1, 1'b0, 1'b1);
        expect_now("min_wrap_no_carry", mk(0, 3, 0, 0, 0, 0, 0, 0));
        run_cycle(1'b0, 1'b1, 1'b0, 1'b0);
        pulse_f2(10);
        run_cycle(1'b0, 1'b1, 1'b1, 1'b1);
        expect_now("both_keys", mk(0, 4, 1, 1, 0, 0, 0, 0));
        run_cycle(1'b0, 1'b1, 1'b0, 1'b0);

        run_n(150, 1'b1);
        expect_now("run_sec37_keys_ignored", mk(0, 4, 1, 1, 3, 7, 0, 0));
        run_cycle(1'b0, 1'b1, 1'b0, 1'b0);
        expect_now("set_clears_seconds", mk(0, 4, 1, 1, 0, 0, 0, 0));

        pulse_f1(15);
        pulse_f2(31);
        expect_now("set_742pm", mk(1, 7, 4, 2, 0, 0, 0, 0));
        run_n(60, 1'b0);
        expect_now("at_7_42_15pm", mk(1, 7, 4, 2, 1, 5, 1, 0));
        run_cycle(1'b1, 1'b1, 1'b1, 1'b0);
        expect_now("reset_over_key_edge", mk(0, 0, 0, 0, 0, 0, 0, 0));
        run_cycle(1'b0, 1'b1, 1'b1, 1'b0);
        expect_now("key_held_through_reset", mk(0, 1, 0, 0, 0, 0, 0, 0));
        run_cycle(1'b0, 1'b1, 1'b1, 1'b0);

        cyc = 0;
        while (cyc < 3000) begin
            s   = 1'($urandom_range(1));
            seg = (s) ? $urandom_range(1, 30) : $urandom_range(1, 400);
            repeat (seg) begin
                r = ($urandom_range(299) == 0);
                run_cycle(r, s, 1'($urandom_range(1)), 1'($urandom_range(1)));
                cyc++;
            end
        end

        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/time_keeper.md
# time_keeper

Free-running time-of-day core for the digital clock. Divides the system clock down to one-second ticks and maintains seconds, minutes, hour and AM/PM in 12-hour form. It accepts front-panel time-setting in set mode and drives the current-time bus (AMPM, HOUR, MINHIGH, MINLOW) that the alarm stage compares against its stored alarm time. The hour encoding matches the alarm's hour counter, so equality compare works directly.

## Interface

- TICKS_PER_SEC, default 1000: CLK cycles per second. Must be ≥ 2.
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- TIMESET_RUN  in  1  1 = set mode, 0 = run mode.
- SW_F1  in  1  hour-advance key. Level input, already debounced and synchronous to CLK.
- SW_F2  in  1  minute-advance key. Same conditioning as SW_F1.
- AMPM  out  1  0 = AM, 1 = PM.
- HOUR  out  4  0..11; 0 means 12 o'clock.
- MINHIGH  out  3  minute tens digit, 0..5.
- MINLOW  out  4  minute units digit, 0..9.
- SECHIGH  out  3  second tens digit, 0..5.
- SECLOW  out  4  second units digit, 0..9.
- SEC_TICK  out  1  one-cycle pulse when seconds advance in run mode.
- MIN_TICK  out  1  one-cycle pulse when minutes advance by seconds rollover.

## Operation

- Reset: all time outputs 0, meaning 12:00:00 AM. SEC_TICK = 0 and MIN_TICK = 0. Prescaler = 0. Key-history registers = 0.
- Prescaler (run mode) counts 0..TICKS_PER_SEC-1. Reaching the terminal count forces a wrap to 0 and generates a second advance.
- Second advance chain:
  - SECLOW 9→0 carries into SECHIGH.
  - SECHIGH 5→0 (at :59) carries into the minute.
  - MINLOW 9→0 carries into MINHIGH.
  - MINHIGH 5→0 carries into HOUR.
  - HOUR 11→0 toggles AMPM. All other hour increments leave AMPM unchanged.
  - The chain is plain BCD-digit counting. Digits never take values outside their stated ranges.
- Set mode (TIMESET_RUN = 1):
  - Prescaler, SECHIGH and SECLOW are held at 0.
  - SEC_TICK and MIN_TICK stay 0.
  - A rising edge of SW_F1 (current = 1, history = 0) advances HOUR by one. The 11→0 wrap toggles AMPM, as in run mode.
  - A rising edge of SW_F2 advances the minute by one, 59→00, with no carry into HOUR.
  - Edges on both keys in the same cycle apply both adjustments in that cycle.
  - A held key produces exactly one advance.
- Run mode: SW_F1 and SW_F2 are ignored.
- Key-history registers update every cycle in both modes. A key held while entering set mode therefore produces no advance.
- Exception after reset: the history registers reset to 0, so a key held high at reset release produces one advance in set mode.
- Mode change run→set mid-second: the prescaler and seconds clear on the first set-mode cycle. Minutes and hours are kept.

## Timing

- All outputs are registered.
- Prescaler at terminal count in cycle N: the new time appears in cycle N+1. SEC_TICK = 1 in cycle N+1 only.
- MIN_TICK = 1 in the same cycle as SEC_TICK when that second advance produced :59→:00. It is never asserted for key-driven minute changes.
- Consecutive SEC_TICK pulses are exactly TICKS_PER_SEC cycles apart.
- Key rising edge sampled in cycle N: the updated HOUR or minute is visible in cycle N+1.
- TIMESET_RUN falling at the edge starting cycle M: the prescaler restarts from 0. The first SEC_TICK occurs in cycle M+TICKS_PER_SEC.
- RST has priority over everything. RST asserted in cycle N gives reset values in cycle N+1, regardless of mode, keys or prescaler state.

## Test plan

All scenarios use TICKS_PER_SEC = 4.

- Reset, then run 4×60 cycles → AMPM = 0, HOUR = 0, MINHIGH = 0, MINLOW = 1, seconds 00. Exactly 60 SEC_TICKs, each 4 cycles apart. One MIN_TICK, coincident with the 60th SEC_TICK.
- Set mode: pulse SW_F1 11 times → HOUR = 11, AMPM = 0. Pulse SW_F1 once more → HOUR = 0, AMPM = 1. Holding SW_F1 high for 20 cycles → only one advance.
- Set mode: set time to 11:59 PM (HOUR = 11, AMPM = 1, MINHIGH = 5, MINLOW = 9), then drop to run mode. After 240 cycles → HOUR = 0, AMPM = 0, MINHIGH = 0, MINLOW = 0, seconds 00, with MIN_TICK = 1 in that cycle.
- Set mode at minute 59 with HOUR = 3: SW_F2 edge → minute 00, HOUR still 3, MIN_TICK = 0. In the same cycle, SW_F1 and SW_F2 edges together from HOUR = 3 / minute 10 → HOUR = 4 / minute 11.
- Run mode mid-second with seconds 37, then raise TIMESET_RUN → next cycle seconds 00 and prescaler 0. Toggling SW_F1/SW_F2 while in run mode beforehand → no change.
- Assert RST for one cycle during a set-mode key edge at 7:42:15 PM → the next cycle reads 12:00:00 AM with SEC_TICK = 0 and MIN_TICK = 0.
